// File: rtl/draw_border_anim.sv
// draw_border_anim -- concentric VGA border bands with an optional bouncing
// crosshair and a blinking (colour-swapped) border, in the pixel clock domain.
//
// Ports:
//   clk      pixel clock
//   rst_n    asynchronous active-low reset
//   de       data enable (active video)
//   frame    one-cycle start-of-frame pulse, issued during blanking
//   sx, sy   current pixel coordinates
//   mode     requested mode (0 static, 1 bounce, 2 blink, 3 bounce+blink),
//            latched on frame
//   pause    freezes crosshair motion and blink counter
//   rgb      registered pixel colour {R,G,B}; 1-cycle latency from de/sx/sy
//   cross_x  crosshair centre x
//   cross_y  crosshair centre y
//
// Optional: define BORDER_GRID_EN to draw a grey 64-px grid in the interior.
module draw_border_anim #(
  parameter int H_RES         = 640,
  parameter int V_RES         = 480,
  parameter int CORDW         = 10,
  parameter int COLR_BITS     = 2,
  parameter int OUTLINE_WIDTH = 5,
  parameter int INNER_WIDTH   = 10,
  parameter int OUTER_WIDTH   = 20,
  parameter int LINE_PADDING  = 5,
  parameter int STEP          = 2,
  parameter int BLINK_FRAMES  = 30
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   de,
  input  logic                   frame,
  input  logic [CORDW-1:0]       sx,
  input  logic [CORDW-1:0]       sy,
  input  logic [1:0]             mode,
  input  logic                   pause,
  output logic [3*COLR_BITS-1:0] rgb,
  output logic [CORDW-1:0]       cross_x,
  output logic [CORDW-1:0]       cross_y
);

  localparam int CW = 3 * COLR_BITS;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [COLR_BITS-1:0] F = '1;
  localparam logic [COLR_BITS-1:0] Z = '0;
  localparam logic [CW-1:0] GREEN = {Z, F, Z};
  localparam logic [CW-1:0] RED   = {F, Z, Z};
  localparam logic [CW-1:0] WHITE = {F, F, F};
  localparam logic [CW-1:0] BLUE  = {Z, Z, F};

  localparam logic [CORDW-1:0] X_CTR = CORDW'(H_RES / 2 - 1);
  localparam logic [CORDW-1:0] Y_CTR = CORDW'(V_RES / 2 - 1);

  // Bounds and step held one bit wider than the coordinates so c+STEP
  // cannot wrap before the comparison.
  localparam logic [CORDW:0] XMIN = (CORDW+1)'(OUTER_WIDTH + LINE_PADDING);
  localparam logic [CORDW:0] XMAX = (CORDW+1)'(H_RES - OUTER_WIDTH - LINE_PADDING - 1);
  localparam logic [CORDW:0] YMIN = (CORDW+1)'(OUTER_WIDTH + LINE_PADDING);
  localparam logic [CORDW:0] YMAX = (CORDW+1)'(V_RES - OUTER_WIDTH - LINE_PADDING - 1);
  localparam logic [CORDW:0] STEPW = (CORDW+1)'(STEP);

  localparam logic [CORDW-1:0] X_LAST = CORDW'(H_RES - 1);
  localparam logic [CORDW-1:0] Y_LAST = CORDW'(V_RES - 1);
  localparam logic [CORDW-1:0] W_OUTL = CORDW'(OUTLINE_WIDTH);
  localparam logic [CORDW-1:0] W_INNR = CORDW'(INNER_WIDTH);
  localparam logic [CORDW-1:0] W_OUTR = CORDW'(OUTER_WIDTH);
  localparam logic [CORDW-1:0] W_PAD  = CORDW'(LINE_PADDING);

  logic [1:0]    mode_q;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;
  logic          dir_x;   // 1 = moving +
  logic          dir_y;

  // One bounce-axis step: returns {new_dir, new_coord}.
  function automatic logic [CORDW:0] step_axis(
    input logic [CORDW-1:0] c,
    input logic             dir,
    input logic [CORDW:0]   cmin,
    input logic [CORDW:0]   cmax
  );
    logic [CORDW:0] cw;
    cw = {1'b0, c};
    if (dir) begin
      if (cw + STEPW > cmax) step_axis = {1'b0, cmax[CORDW-1:0]};
      else                   step_axis = {1'b1, c + STEPW[CORDW-1:0]};
    end else begin
      if (cw < cmin + STEPW) step_axis = {1'b1, cmin[CORDW-1:0]};
      else                   step_axis = {1'b0, c - STEPW[CORDW-1:0]};
    end
  endfunction

  // Frame-rate state: mode latch, blink counter, crosshair motion.
  // All decisions use the pre-update mode_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      cross_x   <= X_CTR;
      cross_y   <= Y_CTR;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
    end else if (frame) begin
      mode_q <= mode;

      if (mode_q[1] && !pause) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end

      if (!mode_q[0]) begin
        cross_x <= X_CTR;
        cross_y <= Y_CTR;
        dir_x   <= 1'b1;
        dir_y   <= 1'b1;
      end else if (!pause) begin
        {dir_x, cross_x} <= step_axis(cross_x, dir_x, XMIN, XMAX);
        {dir_y, cross_y} <= step_axis(cross_y, dir_y, YMIN, YMAX);
      end
    end
  end

  // Pixel colour selection.
  logic [CORDW-1:0] d_x, d_y, d;
  logic [CORDW-1:0] ax, ay;
  logic             on_cross;
  logic             swap;
  logic [CW-1:0]    outline_c, outer_c, pix;

  always_comb begin
    d_x = (sx < X_LAST - sx) ? sx : X_LAST - sx;
    d_y = (sy < Y_LAST - sy) ? sy : Y_LAST - sy;
    d   = (d_x < d_y) ? d_x : d_y;

    ax = (sx >= cross_x) ? sx - cross_x : cross_x - sx;
    ay = (sy >= cross_y) ? sy - cross_y : cross_y - sy;
    on_cross = (ax < W_PAD) || (ay < W_PAD);

    swap      = mode_q[1] && blink_ph;
    outline_c = swap ? RED   : GREEN;
    outer_c   = swap ? GREEN : RED;

    if (!de)                pix = '0;
    else if (d < W_OUTL)    pix = outline_c;
    else if (d < W_INNR)    pix = WHITE;
    else if (d < W_OUTR)    pix = outer_c;
    else if (on_cross)      pix = WHITE;
`ifdef BORDER_GRID_EN
    else if (sx[5:0] == 6'd0 || sy[5:0] == 6'd0)
                            pix = {3{COLR_BITS'(1)}};
`endif
    else                    pix = BLUE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb <= '0;
    else        rgb <= pix;
  end

endmodule
